seq_alu_acc: RTL and testbench
==============================

# seq_alu_acc

Parametrised accumulator ALU: a DATA_W-bit accumulator register combined with an OP_W-bit operand ALU. Single-cycle operations and an iterative multi-cycle shift-add multiply run under a Start/Busy/Done handshake. Carry and Zero status flags are registered alongside the accumulator. It sits between the board switch/key inputs and the HEX/LEDR display logic, and replaces the fixed 8-bit ALU-plus-register pair.

## Interface
- DATA_W, 8, accumulator width; legal range OP_W ≤ DATA_W ≤ 32
- OP_W, 4, operand width; legal range 2..16
- Clock  in  1  rising-edge clock
- Resetn  in  1  reset, synchronous, active-low
- Start  in  1  request to execute Func with operand A; sampled only when Busy=0
- Func  in  3  operation select
- A  in  OP_W  operand, sampled with Start
- Busy  out  1  high while a multiply is in progress
- Done  out  1  one-cycle pulse marking a completed operation
- Acc  out  DATA_W  accumulator value
- Carry  out  1  ADD carry-out or SUB borrow
- Zero  out  1  high when Acc==0

## Operation
- Operand extension: A is zero-extended to DATA_W ("Ae") for every operation.
- Func 000 HOLD: Acc unchanged.
- Func 001 MUL: Acc <= A × Acc[OP_W-1:0].
  - Full 2·OP_W-bit product.
  - Truncated to DATA_W if DATA_W < 2·OP_W; zero-extended otherwise.
- Func 010 SHL: Acc <= Acc << A; result is 0 when A ≥ DATA_W.
- Func 011 AND: Acc <= Acc & Ae.
- Func 100 OR: Acc <= Acc | Ae.
- Func 101 LOAD: Acc <= Ae.
- Func 110 ADD: Acc <= Acc + Ae; Carry = bit DATA_W of the sum.
- Func 111 SUB: Acc <= Acc − Ae (modulo 2^DATA_W); Carry = 1 iff Acc < Ae (borrow).
- Carry is cleared by every completed operation other than ADD/SUB.
- Zero is recomputed on every completed operation from the new Acc.
- FSM states:
  - IDLE → MUL on Start with Func=001. All other Funcs complete in IDLE.
  - MUL → IDLE after OP_W iterations.
- Multiplier algorithm:
  - At entry, latch A (multiplier) and Acc[OP_W-1:0] (multiplicand); clear the partial product.
  - Each iteration adds the shifted multiplicand when the current multiplier bit is 1.
  - Acc is not modified until the final write.

## Timing
- Reset: Acc=0, Carry=0, Zero=1, Busy=0, Done=0, FSM=IDLE. Reset takes priority over everything.
- Reset during MUL aborts the multiply. No Done is issued and Acc=0.
- Single-cycle ops, Start sampled at edge k:
  - Acc, Carry and Zero update at edge k.
  - Done=1 for the cycle k..k+1.
  - Busy stays 0.
- Back-to-back single-cycle ops: Start may be held high on consecutive cycles. Each sampled edge executes one op and produces one Done.
- MUL, Start sampled at edge k:
  - Busy=1 from edge k.
  - Iterations run at edges k+1..k+OP_W.
  - Acc, flags and Done=1 update at edge k+OP_W; Busy=0 at the same edge.
  - Latency is OP_W cycles.
- Start while Busy=1 is ignored: no queuing and no effect on the in-flight multiply.
- A new Start is accepted at the edge immediately after Done from a MUL.
- Done never asserts for two consecutive cycles from one operation.

## Structure
- Package alu_acc_pkg holds:
  - Func encoding localparams: FN_HOLD, FN_MUL, FN_SHL, FN_AND, FN_OR, FN_LOAD, FN_ADD, FN_SUB.
  - FSM state encoding: ST_IDLE, ST_MUL.
- Sub-module shift_add_mul(OP_W):
  - Ports: Clock, Resetn, start, multiplier, multiplicand, done, product[2·OP_W-1:0].
  - Contains the iteration counter and the partial-product register.
  - Top level owns the FSM, the Acc/flag registers and the single-cycle datapath.
- Display decoding stays outside this block.

## Test plan
All scenarios use DATA_W=8, OP_W=4.
- Reset and load:
  - Resetn=0 for 2 cycles → Acc=0x00, Zero=1, Carry=0, Busy=0, Done=0.
  - Then LOAD A=0x9 → Acc=0x09, Zero=0, Done pulse 1 cycle.
- Add with carry: LOAD 0xF, then SHL A=4 (Acc=0xF0), then ADD A=0xF twice.
  - After the first ADD: Acc=0xFF, Carry=0.
  - After the second ADD: Acc=0x0E, Carry=1.
- Subtract with borrow:
  - LOAD 0x3, then SUB A=0x5 → Acc=0xFE, Carry=1, Zero=0.
  - Then SUB A=0xE → Acc=0xF0, Carry=0.
- Multiply latency:
  - LOAD 0xD, then MUL A=0xB → Busy high for exactly 4 cycles, Acc=0x8F, single Done pulse at edge k+4.
  - Start with ADD pulsed mid-multiply → ignored; Acc remains 0x8F.
- Shift boundaries and Zero flag:
  - LOAD 0x1, then SHL A=7 → Acc=0x80.
  - Then SHL A=9 → Acc=0x00, Zero=1.
  - Then AND/OR with A=0x0 → Acc=0x00, Zero=1.
- Reset mid-multiply:
  - LOAD 0x7, then MUL A=0x3, with Resetn=0 at cycle 2 of the multiply → Acc=0, Busy=0, no Done.
  - Next MUL completes normally (Acc=0 × A=0x3 → Acc=0x00, Zero=1).

Source files
------------

// File: rtl/alu_acc_pkg.sv
// Shared encodings for the sequential accumulator ALU: operation select
// codes and the controller state type.
package alu_acc_pkg;

    localparam logic [2:0] FN_HOLD = 3'b000;
    localparam logic [2:0] FN_MUL  = 3'b001;
    localparam logic [2:0] FN_SHL  = 3'b010;
    localparam logic [2:0] FN_AND  = 3'b011;
    localparam logic [2:0] FN_OR   = 3'b100;
    localparam logic [2:0] FN_LOAD = 3'b101;
    localparam logic [2:0] FN_ADD  = 3'b110;
    localparam logic [2:0] FN_SUB  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier. Operands are latched on start; one
// partial-product step runs per clock for OP_W clocks. done/product are
// combinational and valid during the final step so the owner can write the
// result on the same edge the last iteration completes.
module shift_add_mul #(
    parameter int OP_W = 4
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              start,
    input  logic [OP_W-1:0]   multiplier,
    input  logic [OP_W-1:0]   multiplicand,
    output logic              done,
    output logic [2*OP_W-1:0] product
);

    localparam int CW = $clog2(OP_W) + 1;

    logic              active;
    logic [CW-1:0]     cnt;
    logic [OP_W-1:0]   mplier;
    logic [2*OP_W-1:0] mcand;
    logic [2*OP_W-1:0] partial;
    logic [2*OP_W-1:0] next_partial;

    // Partial product after the current iteration's conditional add.
    always_comb begin
        next_partial = partial + (mplier[0] ? mcand : '0);
    end

    assign product = next_partial;
    assign done    = active && (cnt == CW'(OP_W - 1));

    // Operand latch at start, then one shift-add step per clock.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            active  <= 1'b0;
            cnt     <= '0;
            mplier  <= '0;
            mcand   <= '0;
            partial <= '0;
        end else if (start) begin
            active  <= 1'b1;
            cnt     <= '0;
            mplier  <= multiplier;
            mcand   <= (2*OP_W)'(multiplicand);
            partial <= '0;
        end else if (active) begin
            partial <= next_partial;
            mplier  <= mplier >> 1;
            mcand   <= mcand << 1;
            cnt     <= cnt + CW'(1);
            if (cnt == CW'(OP_W - 1))
                active <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_alu_acc.sv
// Accumulator ALU with registered Carry/Zero flags. Single-cycle operations
// complete in IDLE; MUL hands off to the shift-add multiplier and the result
// is written to Acc on the multiplier's final iteration.
module seq_alu_acc
    import alu_acc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic [2:0]        Func,
    input  logic [OP_W-1:0]   A,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Acc,
    output logic              Carry,
    output logic              Zero
);

    // Wide enough for either the full product or the accumulator.
    localparam int EW = (DATA_W > 2*OP_W) ? DATA_W : 2*OP_W;

    state_t            state;
    logic              mul_start;
    logic              mul_done;
    logic [2*OP_W-1:0] mul_product;
    logic [EW-1:0]     prod_ext;
    logic [DATA_W-1:0] prod_fit;

    logic [DATA_W-1:0] ae;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] nxt_acc;
    logic              nxt_carry;

    assign mul_start = (state == ST_IDLE) && Start && (Func == FN_MUL);
    assign Busy      = (state == ST_MUL);
    assign prod_ext  = EW'(mul_product);
    assign prod_fit  = prod_ext[DATA_W-1:0];

    shift_add_mul #(
        .OP_W(OP_W)
    ) u_mul (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .start       (mul_start),
        .multiplier  (A),
        .multiplicand(Acc[OP_W-1:0]),
        .done        (mul_done),
        .product     (mul_product)
    );

    // Single-cycle datapath: next accumulator and carry for the selected op.
    always_comb begin
        ae        = DATA_W'(A);
        sum       = {1'b0, Acc} + {1'b0, ae};
        diff      = {1'b0, Acc} - {1'b0, ae};
        nxt_acc   = Acc;
        nxt_carry = 1'b0;
        case (Func)
            FN_SHL:  nxt_acc = (32'(A) >= DATA_W) ? '0 : (Acc << A);
            FN_AND:  nxt_acc = Acc & ae;
            FN_OR:   nxt_acc = Acc | ae;
            FN_LOAD: nxt_acc = ae;
            FN_ADD: begin
                nxt_acc   = sum[DATA_W-1:0];
                nxt_carry = sum[DATA_W];
            end
            FN_SUB: begin
                nxt_acc   = diff[DATA_W-1:0];
                nxt_carry = diff[DATA_W];
            end
            default: nxt_acc = Acc;
        endcase
    end

    // Controller plus Acc/flag/Done registers.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= ST_IDLE;
            Acc   <= '0;
            Carry <= 1'b0;
            Zero  <= 1'b1;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        if (Func == FN_MUL) begin
                            state <= ST_MUL;
                        end else begin
                            Acc   <= nxt_acc;
                            Carry <= nxt_carry;
                            Zero  <= (nxt_acc == '0);
                            Done  <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        Acc   <= prod_fit;
                        Carry <= 1'b0;
                        Zero  <= (prod_fit == '0);
                        Done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu_acc.sv
// Bench for seq_alu_acc (DATA_W=8, OP_W=4): directed scenarios with literal
// expectations, then random traffic, all checked every cycle against an
// arithmetic model of the accumulator.
module tb_seq_alu_acc;

    localparam int DW = 8;
    localparam int OW = 4;

    logic          clk    = 1'b0;
    logic          rstn   = 1'b0;
    logic          start  = 1'b0;
    logic [2:0]    func   = 3'd0;
    logic [OW-1:0] a      = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] acc;
    logic          carry;
    logic          zero;

    always #5 clk = ~clk;

    seq_alu_acc #(
        .DATA_W(DW),
        .OP_W  (OW)
    ) u_dut (
        .Clock (clk),
        .Resetn(rstn),
        .Start (start),
        .Func  (func),
        .A     (a),
        .Busy  (busy),
        .Done  (done),
        .Acc   (acc),
        .Carry (carry),
        .Zero  (zero)
    );

    int n_vec  = 0;
    int n_miss = 0;
    bit check_en = 1'b0;

    // Model state: plain integers following the operation rules.
    int m_acc   = 0;
    int m_carry = 0;
    int m_zero  = 1;
    int m_done  = 0;
    int m_left  = 0;
    int m_pend  = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endfunction

    // Reference model, advanced on each rising edge from the sampled inputs.
    always @(posedge clk) begin
        int ia;
        ia = int'(a);
        m_done = 0;
        if (!rstn) begin
            m_acc = 0; m_carry = 0; m_zero = 1; m_left = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_acc = m_pend; m_carry = 0; m_zero = (m_acc == 0); m_done = 1;
            end
        end else if (start) begin
            if (func == 3'd1) begin
                m_pend = (ia * (m_acc % 16)) % 256;
                m_left = OW;
            end else begin
                m_carry = 0;
                case (func)
                    3'd2: m_acc = (ia >= DW) ? 0 : (m_acc << ia) % 256;
                    3'd3: m_acc = m_acc & ia;
                    3'd4: m_acc = m_acc | ia;
                    3'd5: m_acc = ia;
                    3'd6: begin
                        m_carry = (m_acc + ia > 255) ? 1 : 0;
                        m_acc   = (m_acc + ia) % 256;
                    end
                    3'd7: begin
                        m_carry = (m_acc < ia) ? 1 : 0;
                        m_acc   = (m_acc - ia + 256) % 256;
                    end
                    default: ;
                endcase
                m_zero = (m_acc == 0);
                m_done = 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("acc",   int'(acc),   m_acc);
            chk("carry", int'(carry), m_carry);
            chk("zero",  int'(zero),  m_zero);
            chk("busy",  int'(busy),  (m_left > 0) ? 1 : 0);
            chk("done",  int'(done),  m_done);
        end
    end

    task automatic op(input logic [2:0] f, input logic [OW-1:0] v);
        start = 1'b1;
        func  = f;
        a     = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 20) chk("mul_timeout", cyc, 4);
    endtask

    initial begin
        int c;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        check_en = 1'b1;
        chk("rst_acc", int'(acc), 0);
        chk("rst_zero", int'(zero), 1);
        chk("rst_carry", int'(carry), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);

        op(3'd5, 4'h9);
        chk("load_acc", int'(acc), 'h09);
        chk("load_zero", int'(zero), 0);
        chk("load_done", int'(done), 1);
        @(negedge clk);
        chk("load_done_drop", int'(done), 0);

        op(3'd5, 4'hF);
        op(3'd2, 4'h4);
        chk("shl4_acc", int'(acc), 'hF0);
        op(3'd6, 4'hF);
        chk("add1_acc", int'(acc), 'hFF);
        chk("add1_carry", int'(carry), 0);
        op(3'd6, 4'hF);
        chk("add2_acc", int'(acc), 'h0E);
        chk("add2_carry", int'(carry), 1);
        chk("model_add2", m_acc, 'h0E);

        op(3'd5, 4'h3);
        op(3'd7, 4'h5);
        chk("sub1_acc", int'(acc), 'hFE);
        chk("sub1_carry", int'(carry), 1);
        chk("sub1_zero", int'(zero), 0);
        op(3'd7, 4'hE);
        chk("sub2_acc", int'(acc), 'hF0);
        chk("sub2_carry", int'(carry), 0);
        chk("model_sub2", m_acc, 'hF0);

        op(3'd5, 4'hD);
        op(3'd1, 4'hB);
        chk("mul_busy", int'(busy), 1);
        chk("mul_nodone", int'(done), 0);
        wait_done(c);
        chk("mul_latency", c, 4);
        chk("mul_done", int'(done), 1);
        chk("mul_acc", int'(acc), 'h8F);
        chk("model_mul", m_acc, 'h8F);
        @(negedge clk);
        chk("mul_done_drop", int'(done), 0);

        op(3'd5, 4'hD);
        op(3'd1, 4'hB);
        @(negedge clk);
        op(3'd6, 4'h5);
        wait_done(c);
        chk("mul_ignore_acc", int'(acc), 'h8F);

        op(3'd5, 4'h1);
        op(3'd2, 4'h7);
        chk("shl7_acc", int'(acc), 'h80);
        op(3'd2, 4'h9);
        chk("shl9_acc", int'(acc), 0);
        chk("shl9_zero", int'(zero), 1);
        op(3'd3, 4'h0);
        chk("and0_zero", int'(zero), 1);
        op(3'd4, 4'h0);
        chk("or0_acc", int'(acc), 0);
        chk("or0_zero", int'(zero), 1);

        op(3'd5, 4'h7);
        op(3'd1, 4'h3);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("mrst_acc", int'(acc), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        repeat (6) @(negedge clk);
        op(3'd1, 4'h3);
        wait_done(c);
        chk("mul0_acc", int'(acc), 0);
        chk("mul0_zero", int'(zero), 1);
        chk("mul0_done", int'(done), 1);

        for (int i = 0; i < 600; i++) begin
            start = 1'($urandom_range(0, 1));
            func  = 3'($urandom_range(0, 7));
            a     = OW'($urandom_range(0, 15));
            rstn  = ($urandom_range(0, 63) != 0);
            @(negedge clk);
        end
        rstn  = 1'b1;
        start = 1'b0;
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
